// File: rtl/fifo_rr_write_arbiter.sv
// Round-robin write-port arbiter for a shared fifo_with_error_detection.
// Grants one requester per cycle with zero-latency pass-through to the FIFO
// write port. On a parity error it holds the FIFO in reset, then resumes.
module fifo_rr_write_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned GNT_W        = 2,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_full,
    input  logic                          fifo_overflow,
    input  logic                          fifo_parity_error,
    output logic                          fifo_rst_n,
    output logic [GNT_W-1:0]              grant_id,
    output logic [1:0]                    state,
    output logic [CNT_W-1:0]              err_count,
    output logic                          proto_err
);

    localparam int unsigned FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t                  fsm_st;
    logic [FC_W-1:0]         flush_cnt;
    logic [GNT_W-1:0]        last_grant;
    logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];
    logic                    eligible;
    logic                    win_found;
    logic [GNT_W-1:0]        winner;
    logic [GNT_W-1:0]        idx;
    logic                    xfer;

    // Unpack the flat payload bus into one word per requester.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Grants only in RUN with room in the FIFO; system reset blocks everything.
    assign eligible = rst_n && (fsm_st == ST_RUN) && !fifo_full;
    assign xfer     = eligible && win_found;
    assign state    = fsm_st;

    // Round-robin search starting just after the last accepted requester.
    always_comb begin
        win_found = 1'b0;
        winner    = '0;
        idx       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = GNT_W'((32'(last_grant) + k) % NUM_REQ);
            if (!win_found && req_valid[idx]) begin
                win_found = 1'b1;
                winner    = idx;
            end
        end
    end

    // Same-cycle handshake and FIFO write for the winner.
    always_comb begin
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = '0;
        if (xfer) begin
            req_ready[winner] = 1'b1;
            fifo_wr_en        = 1'b1;
            fifo_wr_data      = data_arr[winner];
        end
    end

    // Pointer, health supervision and flush/recover sequencing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_st     <= ST_RUN;
            flush_cnt  <= '0;
            last_grant <= GNT_W'(NUM_REQ - 1);
            grant_id   <= '0;
            err_count  <= '0;
            proto_err  <= 1'b0;
            fifo_rst_n <= 1'b1;
        end else begin
            if (fifo_overflow) begin
                proto_err <= 1'b1;
            end
            if (xfer) begin
                last_grant <= winner;
                grant_id   <= winner;
            end
            case (fsm_st)
                ST_RUN: begin
                    if (fifo_parity_error) begin
                        fsm_st     <= ST_FLUSH;
                        fifo_rst_n <= 1'b0;
                        flush_cnt  <= '0;
                        if (err_count != '1) begin
                            err_count <= err_count + CNT_W'(1);
                        end
                    end
                end
                ST_FLUSH: begin
                    if (flush_cnt == FC_W'(FLUSH_CYCLES - 1)) begin
                        fsm_st     <= ST_RECOVER;
                        fifo_rst_n <= 1'b1;
                    end else begin
                        flush_cnt <= flush_cnt + FC_W'(1);
                    end
                end
                ST_RECOVER: begin
                    fsm_st <= ST_RUN;
                end
                default: begin
                    fsm_st <= ST_RUN;
                end
            endcase
        end
    end

endmodule
